alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised multi-cycle ALU: the next-generation execute-stage ALU, run behind a valid/ready handshake. It executes all single-cycle ALU operations with a registered result and adds iterative signed/unsigned multiply and divide that produce a high/low result pair. It sits between the decode/issue stage and writeback, stalling issue through `in_ready` while a multiply or divide is in progress.

## Interface
- `DATA_WIDTH`, 32, operand/result width; power of 2, ≥8.
- `SHAMT_W`, log2(DATA_WIDTH), shift-amount width (derived; do not override).

- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous abort of the operation in flight.
- `in_valid` in 1: operands and op valid.
- `in_ready` out 1: block accepts an operation (state IDLE).
- `A`, `B` in DATA_WIDTH: operands.
- `ALUop` in 5: operation code.
- `out_valid` out 1: result valid; held until consumed.
- `out_ready` in 1: consumer takes the result.
- `Result` out DATA_WIDTH: result, quotient, or low product.
- `Hi` out DATA_WIDTH: high product or remainder; 0 for other ops.
- `Overflow`, `CarryOut`, `Zero` out 1: flags.

## Operation
- Opcodes: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 SLTU, 6 SLL, 7 SRL, 8 SAL (=SLL), 9 SRA, 10 LUI, 11 XOR, 12 NOR, 13 MULT, 14 MULTU, 15 DIV, 16 DIVU. Any other code: Result=0, Hi=0, all flags 0.
- NOR = ~(A|B).
- Shifts shift B by A[SHAMT_W-1:0]; SRA is arithmetic.
- LUI = {B[DATA_WIDTH/2-1:0], DATA_WIDTH/2 zeros}.
- SLT/SLTU: correct signed/unsigned compare, result 0 or 1.
- ADD/SUB: CarryOut = carry out of A+B or A+~B+1 (for SUB, 1 = no borrow). Overflow = signed overflow.
- Flags: Zero = (Result==0) for AND/OR/ADD/SUB/XOR/NOR; for MULT/MULTU Zero = ({Hi,Result}==0). Overflow, CarryOut and Zero are 0 for all other ops except DIV overflow (below).
- MULT/MULTU: full 2·DATA_WIDTH product {Hi,Result}. Implemented as shift-add on magnitudes, with the sign applied at completion.
- DIV/DIVU: restoring division. Quotient goes to Result, remainder to Hi. Signed quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: Result = all ones, Hi = A, Overflow = 0.
- DIV of the most-negative value by −1: Result = most-negative, Hi = 0, Overflow = 1.
- FSM:
  - IDLE: `in_ready`=1. Accept on `in_valid & ~flush`. A single-cycle op loads the output registers and goes to DONE. A mul/div op latches operands, clears the counter and goes to CALC.
  - CALC: one iteration per cycle, counter 0..DATA_WIDTH-1. After the final iteration, load the outputs and go to DONE.
  - DONE: `out_valid`=1. On `out_ready`, return to IDLE.
- `flush` in any state: next state IDLE, `out_valid` 0, in-flight work discarded. `flush` overrides `in_valid` and `out_ready` in the same cycle.
- `Result`/`Hi`/flags hold their last values after consumption; they are only updated on a new completion.

## Timing
- Reset (asynchronous, while `resetn`=0):
  - State IDLE, counter 0.
  - `out_valid`, `Result`, `Hi`, `Overflow`, `CarryOut`, `Zero` all 0.
  - `in_ready` = 1 (combinational from IDLE).
- Reset asserted mid-CALC or mid-DONE aborts the operation immediately.
- Single-cycle ops: accepted at edge N, `out_valid`=1 after edge N+1.
- Mul/div: accepted at edge N, `out_valid`=1 after edge N+DATA_WIDTH+1.
- Only one operation is in flight; `in_ready`=0 from acceptance until the cycle after the `out_valid & out_ready` handshake.
- `out_valid` never drops without the handshake, `flush`, or reset. Outputs stay stable while `out_valid & ~out_ready`.
- Inputs are sampled only at acceptance; A/B/ALUop changes during CALC have no effect.

## Test plan
- ADD A=0x7FFFFFFF, B=1 -> Result=0x80000000, Overflow=1, CarryOut=0, Zero=0, `out_valid` one cycle after accept.
- SUB A=5, B=5 -> Result=0, Zero=1, CarryOut=1, Overflow=0. SLT A=0xFFFFFFFF, B=1 -> Result=1.
- MULT A=0xFFFFFFFD (−3), B=7 -> Hi=0xFFFFFFFF, Result=0xFFFFFFEB, `out_valid` exactly 33 cycles after accept. MULTU on the same operands -> Hi=6, Result=0xFFFFFFEB.
- DIV A=−7, B=2 -> Result=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU A=7, B=0 -> Result=0xFFFFFFFF, Hi=7. DIV A=0x80000000, B=0xFFFFFFFF -> Result=0x80000000, Hi=0, Overflow=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` with `in_valid`=1 -> outputs stable, `in_ready`=0, no second accept. Raise `out_ready` -> handshake, then `in_ready`=1 the next cycle.
- Abort: `flush` at cycle 10 of a DIVU -> `out_valid` never rises, IDLE next cycle. Drop `resetn` during MULT CALC -> all outputs 0 immediately, `in_ready`=1.

Source files
------------

// File: rtl/alu_mc_if.sv
// alu_mc issue/result bundle: operand handshake in, result handshake out.
// The slave modport is the ALU side, the master modport the issue side.
interface alu_mc_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [4:0]            ALUop;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] Result;
  logic [DATA_WIDTH-1:0] Hi;
  logic                  Overflow;
  logic                  CarryOut;
  logic                  Zero;

  modport slave (
    input  in_valid, A, B, ALUop, out_ready,
    output in_ready, out_valid, Result, Hi,
    output Overflow, CarryOut, Zero
  );

  modport master (
    output in_valid, A, B, ALUop, out_ready,
    input  in_ready, out_valid, Result, Hi,
    input  Overflow, CarryOut, Zero
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle execute ALU: registered single-cycle ops plus iterative
// shift-add multiply and restoring divide behind a valid/ready handshake.
module alu_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic clk,
  input  logic resetn,
  input  logic flush,
  alu_mc_if.slave bus
);

  localparam int W = DATA_WIDTH;

  localparam logic [4:0] OP_AND   = 5'd0;
  localparam logic [4:0] OP_OR    = 5'd1;
  localparam logic [4:0] OP_ADD   = 5'd2;
  localparam logic [4:0] OP_SUB   = 5'd3;
  localparam logic [4:0] OP_SLT   = 5'd4;
  localparam logic [4:0] OP_SLTU  = 5'd5;
  localparam logic [4:0] OP_SLL   = 5'd6;
  localparam logic [4:0] OP_SRL   = 5'd7;
  localparam logic [4:0] OP_SAL   = 5'd8;
  localparam logic [4:0] OP_SRA   = 5'd9;
  localparam logic [4:0] OP_LUI   = 5'd10;
  localparam logic [4:0] OP_XOR   = 5'd11;
  localparam logic [4:0] OP_NOR   = 5'd12;
  localparam logic [4:0] OP_MULT  = 5'd13;
  localparam logic [4:0] OP_MULTU = 5'd14;
  localparam logic [4:0] OP_DIV   = 5'd15;
  localparam logic [4:0] OP_DIVU  = 5'd16;

  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SHAMT_W-1:0] cnt_q;
  logic [W-1:0]       hi_q, lo_q, opnd_q, a_q;
  logic [4:0]         op_q;
  logic               negq_q, negr_q, dz_q, ovf_q;

  logic [W-1:0] res_q, rhi_q;
  logic         fov_q, fcy_q, fz_q;

  logic accept, is_md, last, done_md;

  assign is_md   = bus.ALUop inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  assign accept  = (state_q == S_IDLE) && bus.in_valid && !flush;
  assign last    = (cnt_q == SHAMT_W'(W - 1));
  assign done_md = (state_q == S_CALC) && last;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = is_md ? S_CALC : S_DONE;
      S_CALC: if (last) state_d = S_DONE;
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
  end

  logic [W:0]         sum, dif;
  logic [SHAMT_W-1:0] shamt;
  logic [W-1:0]       sc_res;
  logic               sc_ov, sc_cy, sc_z, z_en;

  assign shamt = bus.A[SHAMT_W-1:0];

  always_comb begin
    sum    = {1'b0, bus.A} + {1'b0, bus.B};
    dif    = {1'b0, bus.A} + {1'b0, ~bus.B} + {{W{1'b0}}, 1'b1};
    sc_res = '0;
    sc_ov  = 1'b0;
    sc_cy  = 1'b0;
    z_en   = 1'b0;
    case (bus.ALUop)
      OP_AND: begin
        sc_res = bus.A & bus.B;
        z_en   = 1'b1;
      end
      OP_OR: begin
        sc_res = bus.A | bus.B;
        z_en   = 1'b1;
      end
      OP_ADD: begin
        sc_res = sum[W-1:0];
        sc_cy  = sum[W];
        sc_ov  = (bus.A[W-1] == bus.B[W-1]) &&
                 (sum[W-1] != bus.A[W-1]);
        z_en   = 1'b1;
      end
      OP_SUB: begin
        sc_res = dif[W-1:0];
        sc_cy  = dif[W];
        sc_ov  = (bus.A[W-1] != bus.B[W-1]) &&
                 (dif[W-1] != bus.A[W-1]);
        z_en   = 1'b1;
      end
      OP_SLT:
        sc_res = {{(W-1){1'b0}},
                  $signed(bus.A) < $signed(bus.B)};
      OP_SLTU:
        sc_res = {{(W-1){1'b0}}, bus.A < bus.B};
      OP_SLL, OP_SAL:
        sc_res = bus.B << shamt;
      OP_SRL:
        sc_res = bus.B >> shamt;
      OP_SRA:
        sc_res = W'($signed(bus.B) >>> shamt);
      OP_LUI:
        sc_res = {bus.B[W/2-1:0], {(W/2){1'b0}}};
      OP_XOR: begin
        sc_res = bus.A ^ bus.B;
        z_en   = 1'b1;
      end
      OP_NOR: begin
        sc_res = ~(bus.A | bus.B);
        z_en   = 1'b1;
      end
      default: ;
    endcase
    sc_z = z_en && (sc_res == '0);
  end

  // Operands are reduced to magnitudes; signs are reapplied at completion.
  logic         sgn_in, mul_in, a_neg, b_neg;
  logic [W-1:0] mag_a, mag_b;

  always_comb begin
    sgn_in = (bus.ALUop == OP_MULT) || (bus.ALUop == OP_DIV);
    mul_in = (bus.ALUop == OP_MULT) || (bus.ALUop == OP_MULTU);
    a_neg  = sgn_in && bus.A[W-1];
    b_neg  = sgn_in && bus.B[W-1];
    mag_a  = a_neg ? (~bus.A + 1'b1) : bus.A;
    mag_b  = b_neg ? (~bus.B + 1'b1) : bus.B;
  end

  logic         is_mul_q;
  logic [W:0]   msum, shifted, trial;
  logic [W-1:0] it_hi, it_lo;

  assign is_mul_q = (op_q == OP_MULT) || (op_q == OP_MULTU);

  always_comb begin
    msum    = {1'b0, hi_q} + {1'b0, lo_q[0] ? opnd_q : '0};
    shifted = {hi_q, lo_q[W-1]};
    trial   = shifted - {1'b0, opnd_q};
    if (is_mul_q) begin
      {it_hi, it_lo} = {msum, lo_q[W-1:1]};
    end else if (!trial[W]) begin
      it_hi = trial[W-1:0];
      it_lo = {lo_q[W-2:0], 1'b1};
    end else begin
      it_hi = shifted[W-1:0];
      it_lo = {lo_q[W-2:0], 1'b0};
    end
  end

  logic [2*W-1:0] prod, prod_s;
  logic [W-1:0]   fin_res, fin_hi;
  logic           fin_ov, fin_z;

  always_comb begin
    prod    = {it_hi, it_lo};
    prod_s  = negq_q ? (~prod + 1'b1) : prod;
    fin_res = '0;
    fin_hi  = '0;
    fin_ov  = 1'b0;
    fin_z   = 1'b0;
    if (is_mul_q) begin
      fin_res = prod_s[W-1:0];
      fin_hi  = prod_s[2*W-1:W];
      fin_z   = (prod_s == '0);
    end else if (dz_q) begin
      fin_res = '1;
      fin_hi  = a_q;
    end else if (ovf_q) begin
      fin_res = MIN_NEG;
      fin_ov  = 1'b1;
    end else begin
      fin_res = negq_q ? (~it_lo + 1'b1) : it_lo;
      fin_hi  = negr_q ? (~it_hi + 1'b1) : it_hi;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      a_q    <= '0;
      op_q   <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
      res_q  <= '0;
      rhi_q  <= '0;
      fov_q  <= 1'b0;
      fcy_q  <= 1'b0;
      fz_q   <= 1'b0;
    end else begin
      if (accept && is_md) begin
        op_q   <= bus.ALUop;
        a_q    <= bus.A;
        hi_q   <= '0;
        cnt_q  <= '0;
        lo_q   <= mul_in ? mag_b : mag_a;
        opnd_q <= mul_in ? mag_a : mag_b;
        negq_q <= a_neg ^ b_neg;
        negr_q <= !mul_in && a_neg;
        dz_q   <= (bus.B == '0);
        ovf_q  <= (bus.ALUop == OP_DIV) &&
                  (bus.A == MIN_NEG) && (bus.B == '1);
      end else if (state_q == S_CALC) begin
        hi_q  <= it_hi;
        lo_q  <= it_lo;
        cnt_q <= cnt_q + SHAMT_W'(1);
      end
      if (accept && !is_md) begin
        res_q <= sc_res;
        rhi_q <= '0;
        fov_q <= sc_ov;
        fcy_q <= sc_cy;
        fz_q  <= sc_z;
      end else if (done_md && !flush) begin
        res_q <= fin_res;
        rhi_q <= fin_hi;
        fov_q <= fin_ov;
        fcy_q <= 1'b0;
        fz_q  <= fin_z;
      end
    end
  end

  always_comb begin
    bus.Result   = res_q;
    bus.Hi       = rhi_q;
    bus.Overflow = fov_q;
    bus.CarryOut = fcy_q;
    bus.Zero     = fz_q;
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: expected results are queued at issue and
// compared when the result handshake completes.
module tb_alu_mc;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic        ov;
    logic        cy;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  logic flush;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  alu_mc_if #(.DATA_WIDTH(32)) bus ();

  alu_mc #(.DATA_WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [4:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t   e;
    longint s;
    logic [63:0] u;
    int     ia, ib;
    e  = '0;
    ia = a;
    ib = b;
    case (op)
      5'd0:  e.res = a & b;
      5'd1:  e.res = a | b;
      5'd2: begin
        u = {32'd0, a} + {32'd0, b};
        s = longint'($signed(a)) + longint'($signed(b));
        e.res = u[31:0];
        e.cy  = u[32];
        e.ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd3: begin
        u = {32'd0, a} + {32'd0, ~b} + 64'd1;
        s = longint'($signed(a)) - longint'($signed(b));
        e.res = u[31:0];
        e.cy  = u[32];
        e.ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd4:  e.res = (ia < ib) ? 32'd1 : 32'd0;
      5'd5:  e.res = (a < b) ? 32'd1 : 32'd0;
      5'd6, 5'd8: e.res = b << a[4:0];
      5'd7:  e.res = b >> a[4:0];
      5'd9:  e.res = ib >>> a[4:0];
      5'd10: e.res = {b[15:0], 16'h0};
      5'd11: e.res = a ^ b;
      5'd12: e.res = ~(a | b);
      5'd13, 5'd14: begin
        if (op == 5'd13) u = longint'(ia) * longint'(ib);
        else u = {32'd0, a} * {32'd0, b};
        {e.hi, e.res} = u;
        e.z = (u == 64'd0);
      end
      5'd15, 5'd16: begin
        if (b == 32'd0) begin
          e.res = 32'hFFFF_FFFF;
          e.hi  = a;
        end else if (op == 5'd15 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.res = 32'h8000_0000;
          e.ov  = 1'b1;
        end else if (op == 5'd15) begin
          e.res = ia / ib;
          e.hi  = ia % ib;
        end else begin
          e.res = a / b;
          e.hi  = a % b;
        end
      end
      default: ;
    endcase
    if (op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd11, 5'd12})
      e.z = (e.res == 32'd0);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (resetn && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("res", {32'd0, bus.Result}, {32'd0, e.res});
        check("hi", {32'd0, bus.Hi}, {32'd0, e.hi});
        check("flags",
              {61'd0, bus.Overflow, bus.CarryOut, bus.Zero},
              {61'd0, e.ov, e.cy, e.z});
      end
    end
  end

  task automatic run_op(input logic [4:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input exp_t e);
    int k;
    bit seen;
    sb.push_back(e);
    bus.ALUop     = op;
    bus.A         = a;
    bus.B         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 100) begin
      @(posedge clk);
      #1;
      k++;
      bus.in_valid = 1'b0;
      bus.A = $urandom;
      bus.B = $urandom;
      if (bus.out_valid) seen = 1'b1;
    end
    check("latency", 64'(k), (op inside {[5'd13:5'd16]}) ? 64'd33 : 64'd1);
    @(posedge clk);
    #1;
    check("ready_after", {63'd0, bus.in_ready}, 64'd1);
  endtask

  initial begin
    exp_t e;
    logic [4:0]  op;
    logic [31:0] a, b;
    int seen_v;
    resetn        = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.ALUop     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_outs",
          {bus.Result, bus.Hi[28:0], bus.Overflow, bus.CarryOut, bus.Zero},
          64'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    e = '{res: 32'h8000_0000, hi: 0, ov: 1, cy: 0, z: 0};
    run_op(5'd2, 32'h7FFF_FFFF, 32'd1, e);
    e = '{res: 0, hi: 0, ov: 0, cy: 1, z: 1};
    run_op(5'd3, 32'd5, 32'd5, e);
    e = '{res: 1, hi: 0, ov: 0, cy: 0, z: 0};
    run_op(5'd4, 32'hFFFF_FFFF, 32'd1, e);
    e = '{res: 32'hFFFF_FFEB, hi: 32'hFFFF_FFFF, ov: 0, cy: 0, z: 0};
    run_op(5'd13, 32'hFFFF_FFFD, 32'd7, e);
    e = '{res: 32'hFFFF_FFEB, hi: 32'd6, ov: 0, cy: 0, z: 0};
    run_op(5'd14, 32'hFFFF_FFFD, 32'd7, e);
    e = '{res: 32'hFFFF_FFFD, hi: 32'hFFFF_FFFF, ov: 0, cy: 0, z: 0};
    run_op(5'd15, 32'hFFFF_FFF9, 32'd2, e);
    e = '{res: 32'hFFFF_FFFF, hi: 32'd7, ov: 0, cy: 0, z: 0};
    run_op(5'd16, 32'd7, 32'd0, e);
    e = '{res: 32'h8000_0000, hi: 0, ov: 1, cy: 0, z: 0};
    run_op(5'd15, 32'h8000_0000, 32'hFFFF_FFFF, e);

    for (int i = 0; i < 24; i++) begin
      op = 5'($urandom_range(0, 18));
      a  = $urandom;
      b  = (i % 4 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op(op, a, b, model(op, a, b));
    end

    // Backpressure: result held, second request must wait.
    sb.push_back('{res: 32'd7, hi: 0, ov: 0, cy: 0, z: 0});
    bus.ALUop     = 5'd2;
    bus.A         = 32'd3;
    bus.B         = 32'd4;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.A = 32'd1;
    bus.B = 32'd1;
    check("bp_valid", {63'd0, bus.out_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold",
            {bus.out_valid, bus.in_ready, 30'd0, bus.Result},
            {1'b1, 1'b0, 30'd0, 32'd7});
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);

    // Flush wins over a simultaneous request in IDLE.
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.ALUop    = 5'd0;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_idle", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);

    // Flush ten cycles into a divide.
    bus.ALUop    = 5'd16;
    bus.A        = 32'd100;
    bus.B        = 32'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("div_busy", {63'd0, bus.in_ready}, 64'd0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_calc", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);
    seen_v = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen_v++;
    end
    check("flush_novalid", 64'(seen_v), 64'd0);

    // Asynchronous reset in the middle of a multiply.
    bus.ALUop    = 5'd13;
    bus.A        = 32'd9;
    bus.B        = 32'd9;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("arst_ready", {63'd0, bus.in_ready}, 64'd1);
    check("arst_outs",
          {bus.out_valid, bus.Result, bus.Hi[27:0],
           bus.Overflow, bus.CarryOut, bus.Zero},
          64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    e = model(5'd14, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op(5'd14, 32'h1234_5678, 32'h9ABC_DEF0, e);

    check("sb_left", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
